// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite frame sequencer.
package sprite_pkg;

   localparam int unsigned X_W           = 9;
   localparam int unsigned Y_W           = 8;
   localparam int unsigned COLOUR_W      = 3;
   localparam int unsigned SPRITE_PIXELS = 40;
   localparam int unsigned SETUP_CYCLES  = 3;

   localparam logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StErase = 3'd1;
   localparam state_t StGap   = 3'd2;
   localparam state_t StDraw  = 3'd3;
   localparam state_t StNext  = 3'd4;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter; tick is high for the single wrap cycle of each frame.
module frame_timer
   import sprite_pkg::*;
#(
   parameter int unsigned FRAME_TICKS = 833333
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame walk over all sprites: erase old image, then draw new one, muxing the
// selected sprite onto the VGA write port.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int unsigned N_SPRITES     = 4,
   parameter int unsigned FRAME_TICKS   = 833333,
   parameter int unsigned SETUP_CYCLES  = 3,
   parameter int unsigned SPRITE_PIXELS = 40,
   parameter int unsigned DRAW_TIMEOUT  = 63
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_SPRITES-1:0]          finish,
   input  logic [X_W*N_SPRITES-1:0]      sprite_x,
   input  logic [Y_W*N_SPRITES-1:0]      sprite_y,
   input  logic [COLOUR_W*N_SPRITES-1:0] sprite_colour,
   output logic [N_SPRITES-1:0]          draw_signal,
   output logic [N_SPRITES-1:0]          erase_signal,
   output logic [X_W-1:0]                vga_x,
   output logic [Y_W-1:0]                vga_y,
   output logic [COLOUR_W-1:0]           vga_colour,
   output logic                          vga_plot,
   output logic                          busy,
   output logic                          overrun,
   output logic                          timeout_err
);

   localparam int unsigned SEL_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_SPRITES - 1);
   localparam logic [5:0] PLOT_FIRST      = 6'(SETUP_CYCLES);
   localparam logic [5:0] PLOT_LAST       = 6'(SETUP_CYCLES + SPRITE_PIXELS - 1);
   localparam logic [5:0] ERASE_LAST      = 6'(SETUP_CYCLES + SPRITE_PIXELS);
   localparam logic [5:0] TIMEOUT_CNT     = 6'(DRAW_TIMEOUT);

   state_t                 state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [5:0]             cnt_q, cnt_d;
   logic [N_SPRITES-1:0]   drawn_q, drawn_d;
   logic [N_SPRITES-1:0]   draw_q, draw_d, erase_q, erase_d;
   logic                   pending_q, pending_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q, timeout_d;
   logic                   plot_q, plot_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   logic [COLOUR_W-1:0]    colour_q, colour_d;
   logic                   tick, consume, sel_finish;

   frame_timer #(
      .FRAME_TICKS(FRAME_TICKS)
   ) u_frame_timer (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign sel_finish = finish[sel_q];

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      drawn_d   = drawn_q;
      timeout_d = timeout_q;
      consume   = 1'b0;
      case (state_q)
         StIdle: begin
            if (pending_q) begin
               consume = 1'b1;
               sel_d   = '0;
               state_d = drawn_q[0] ? StErase : StDraw;
            end
         end
         StErase: if (cnt_q == ERASE_LAST) state_d = StGap;
         StGap:   state_d = StDraw;
         StDraw: begin
            if (sel_finish) begin
               drawn_d[sel_q] = 1'b1;
               state_d        = StNext;
            end else if (cnt_q == TIMEOUT_CNT) begin
               timeout_d      = 1'b1;
               drawn_d[sel_q] = 1'b0;
               state_d        = StNext;
            end
         end
         StNext: begin
            if (sel_q == SEL_LAST) begin
               state_d = StIdle;
            end else begin
               sel_d   = sel_q + 1'b1;
               state_d = drawn_q[sel_d] ? StErase : StDraw;
            end
         end
         default: state_d = StIdle;
      endcase

      cnt_d  = (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + 1'b1;
      busy_d = (state_d != StIdle);

      // Requests decode the next state so the flops present them glitch-free.
      draw_d  = '0;
      erase_d = '0;
      if (state_d == StDraw)  draw_d[sel_d]  = 1'b1;
      if (state_d == StErase) erase_d[sel_d] = 1'b1;

      // A wrap coinciding with the IDLE consume just re-arms pending.
      pending_d = pending_q;
      if (consume) pending_d = 1'b0;
      if (tick)    pending_d = 1'b1;
      overrun_d = overrun_q | (tick & ((pending_q & ~consume) | busy_q));

      plot_d = 1'b0;
      if (state_q == StErase) begin
         plot_d = (cnt_q >= PLOT_FIRST) && (cnt_q <= PLOT_LAST);
      end else if (state_q == StDraw) begin
         plot_d = (cnt_q >= PLOT_FIRST) && !sel_finish;
      end
      x_d      = sprite_x[int'(sel_q)*X_W +: X_W];
      y_d      = sprite_y[int'(sel_q)*Y_W +: Y_W];
      colour_d = (state_q == StErase) ? ERASE_COLOUR
                                      : sprite_colour[int'(sel_q)*COLOUR_W +: COLOUR_W];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         cnt_q     <= '0;
         drawn_q   <= '0;
         draw_q    <= '0;
         erase_q   <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         plot_q    <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         drawn_q   <= drawn_d;
         draw_q    <= draw_d;
         erase_q   <= erase_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         plot_q    <= plot_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
      end
   end

   assign draw_signal  = draw_q;
   assign erase_signal = erase_q;
   assign vga_x        = x_q;
   assign vga_y        = y_q;
   assign vga_colour   = colour_q;
   assign vga_plot     = plot_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign timeout_err  = timeout_q;

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Frame-level sequencer between the game-tick source and the sprite blocks (player, alien_N, bullet). Once per frame it walks sprites 0..N_SPRITES-1 in order, erasing each sprite's previous image and then drawing its new one through that sprite's draw_signal/erase_signal/finish handshake. It multiplexes the selected sprite's x/y/colour onto the VGA adapter write port and generates the plot strobe. It is the only driver of the VGA adapter's x, y, colour and writeEn.

## Interface
Parameters:
- N_SPRITES, 4: number of sprite blocks served.
- FRAME_TICKS, 833333: clk cycles per frame (60 Hz at 50 MHz).
- SETUP_CYCLES, 3: cycles from handshake assertion to first valid pixel.
- SPRITE_PIXELS, 40: pixels per sprite image.
- DRAW_TIMEOUT, 63: maximum cycles in DRAW before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- finish  in  N_SPRITES  per-sprite draw-complete level.
- sprite_x  in  9*N_SPRITES  packed pixel x, sprite i at [9i+8:9i].
- sprite_y  in  8*N_SPRITES  packed pixel y.
- sprite_colour  in  3*N_SPRITES  packed pixel colour.
- draw_signal  out  N_SPRITES  one-hot draw request.
- erase_signal  out  N_SPRITES  one-hot erase request.
- vga_x  out  9  pixel x to adapter.
- vga_y  out  8  pixel y to adapter.
- vga_colour  out  3  pixel colour to adapter.
- vga_plot  out  1  adapter write enable.
- busy  out  1  high while a frame walk is in progress.
- overrun  out  1  sticky: frame tick arrived while busy.
- timeout_err  out  1  sticky: a draw exceeded DRAW_TIMEOUT.

## Operation
- States: IDLE, ERASE, GAP, DRAW, NEXT. Index register sel (0..N_SPRITES-1). Cycle counter cnt (6 bits) clears on every state entry. Per-sprite drawn flags, all 0 at reset.
- IDLE: wait for tick_pending; on it, clear tick_pending, sel=0, busy=1, go to ERASE if drawn[0] else DRAW.
- ERASE: erase_signal[sel]=1 held for exactly SETUP_CYCLES+SPRITE_PIXELS+1 = 44 cycles (the sprite signals no erase completion), then GAP.
- GAP: all requests low for 1 cycle so the sprite returns to its draw-wait state. Then DRAW.
- DRAW: draw_signal[sel]=1 held until finish[sel]=1 is sampled, then drawn[sel]=1 and NEXT. If cnt reaches DRAW_TIMEOUT, set timeout_err, drawn[sel]=0, go to NEXT.
- NEXT: all requests low 1 cycle; if sel==N_SPRITES-1, go to IDLE with busy=0; else sel+1, then ERASE or DRAW per drawn[sel+1].
- Plot: vga_plot=1 in ERASE for cnt in [SETUP_CYCLES, SETUP_CYCLES+SPRITE_PIXELS-1], and in DRAW for cnt≥SETUP_CYCLES while finish[sel]=0. Otherwise 0.
- Mux: vga_x/vga_y/vga_colour = selected slice of sprite_x/sprite_y/sprite_colour, registered one cycle, with vga_plot registered alongside so they stay aligned. In ERASE, vga_colour is forced to 3'b000.
- Frame timer: counts 0..FRAME_TICKS-1 and wraps. Each wrap sets tick_pending. If tick_pending is already set or busy=1 at wrap, set overrun. Pending depth is 1, so extra ticks are dropped.
- Never assert draw_signal and erase_signal in the same cycle or to more than one sprite.

## Timing
- Reset (asynchronous, low): state IDLE, sel=0, cnt=0, frame timer 0, tick_pending=0, drawn=0. All outputs 0.
- draw_signal and erase_signal are registered outputs with no glitches. Sprites use the draw_signal rising edge as a position-update clock.
- Per-sprite cost: 44 (erase) + 1 (gap) + draw (about 44) + 1 (next) cycles. With N_SPRITES=4, a walk takes about 360 cycles, far below FRAME_TICKS.
- First frame after reset: draw only, no erase.
- Reset asserted mid-walk: immediate abort. Requests drop asynchronously, and drawn flags clear, so the next frame redraws without erasing.
- finish[sel] high on the first DRAW cycle: accept it (drawn=1) and emit no plot.
- finish from a non-selected sprite is ignored.
- Frame wrap in the same cycle IDLE consumes tick_pending: set pending again and do not flag overrun.

## Structure
- Package sprite_pkg holds:
  - the state enum;
  - SPRITE_PIXELS, SETUP_CYCLES, ERASE_COLOUR=3'b000;
  - the coordinate widths 9 and 8.
- Sub-module frame_timer (parameter FRAME_TICKS; ports clk, reset, tick pulse) holds the frame counter. Pending and overrun logic stays in the top level.

## Test plan
- Reset, then the first tick with N_SPRITES=2 and behavioural sprite models: draw_signal[0] rises, no erase precedes it, and exactly 40 vga_plot pulses occur per sprite. busy falls about 90 cycles after the tick.
- Second tick: erase_signal[0] is high for exactly 44 cycles with 40 plots of colour 000. The gap is 1 cycle, then draw_signal[0] rises.
- Sprite 1 model never raises finish: DRAW aborts at cnt=63, timeout_err=1, and the next frame skips the erase for sprite 1.
- FRAME_TICKS=50 with a busy walk: overrun=1, and only one queued walk runs after busy falls.
- reset pulsed low during sprite 0 ERASE at cnt=20: all outputs read 0 during reset. The next tick does a draw-only walk.
- Throughout all tests, the bench asserts draw_signal and erase_signal are never both high and are always one-hot or zero.
